display_source_mux: RTL and testbench
=====================================

# display_source_mux

Parametrised pixel-source arbiter for the camera-to-LCD path. It sits between the image-processing stages (RGB, gray, histogram, threshold, multi-threshold and similar) and the SDRAM write port feeding the touch-panel TCON. It selects one of `NUM_CH` RGB sources and packs the selected pixel, plus a delayed 8-bit gray side-band, into the two 16-bit write words. Unlike a plain per-cycle mux, source changes are debounced over whole frames and applied only at a frame boundary, so the display never tears mid-frame.

## Interface
Parameters:
- `NUM_CH`, 8: number of selectable sources, ≥2.
- `PIX_W`, 12: per-colour width of each source, ≥8.
- `SETTLE_FRAMES`, 2: frame starts a new request must stay stable before it is applied, ≥1.
- `FVAL_TIMEOUT`, 2**20: cycles without a frame start, while pending, after which the switch is forced, ≥1.
- `FALLBACK_RGB`, {8'hFF,4'h0, 8'hFF,4'h0, 12'h0}: {R,G,B} shown when no legal source is active (yellow).

Ports:
- `iClk`  in  1  clock.
- `iRst_n`  in  1  reset, synchronous, active-low.
- `iFval`  in  1  camera frame-valid; a frame start is a rising edge.
- `iSelect`  in  NUM_CH  one-hot source request.
- `iCh_RGB`  in  NUM_CH*3*PIX_W  channel k at [k*3*PIX_W +: 3*PIX_W], ordered {R,G,B}.
- `iCh_Valid`  in  NUM_CH  per-channel pixel valid.
- `iCh_Mark`  in  NUM_CH  per-channel overlay flag; the pixel is forced red.
- `iGray`  in  8  gray side-band.
- `oWr1_data`  out  16  TCON write word 1.
- `oWr2_data`  out  16  TCON write word 2.
- `oWr_data_valid`  out  1  write strobe.
- `oActive`  out  NUM_CH  applied select; 0 means fallback.
- `oSwitching`  out  1  high while a change is pending.

## Operation
- Request normalisation: `iSelect` is registered as `req`. A non-one-hot request (zero or multi-hot) is normalised to 0, meaning fallback.
- Frame-start detect: `fs` = `iFval` & ~`fval_d`, where `fval_d` is the registered `iFval`.
- Candidate tracking:
  - If `req` ≠ `cand`: `cand`←`req`, `fcnt`←0, `tcnt`←0.
- STEADY (`cand` == `active`):
  - Idle.
  - Goes to PENDING the cycle after `cand` differs from `active`.
- PENDING (`cand` ≠ `active`):
  - Each `fs` increments `fcnt`; every non-`fs` cycle increments `tcnt`.
  - When `fcnt` reaches `SETTLE_FRAMES` on an `fs` cycle, or `tcnt` reaches `FVAL_TIMEOUT`: `active`←`cand`, go to STEADY.
  - A new `req` restarts counting. If the new `req` equals `active`, return to STEADY without switching.
- `oSwitching` = (state == PENDING). `oActive` = `active`.
- Pixel path, registered once from inputs:
  - Active one-hot k, `iCh_Valid[k]`=1, `iCh_Mark[k]`=1: R={8'hFF,0…}, G=B=0, valid=1.
  - Active one-hot k, `iCh_Valid[k]`=1, `iCh_Mark[k]`=0: RGB = channel k, valid=1.
  - Active one-hot k, `iCh_Valid[k]`=0: RGB=0, valid=0.
  - Active = 0: RGB=`FALLBACK_RGB`, valid=`iCh_Valid[0]`.
- Gray side-band: `dGray`←`iGray` every cycle.
- Packing, using the top bits of each PIX_W colour:
  - Wr1 = {dGray[7], G[PIX_W-1 -:5], B[PIX_W-1 -:8], dGray[6:5]}.
  - Wr2 = {dGray[4], G[PIX_W-6 -:3], dGray[3:2], R[PIX_W-1 -:8], dGray[1:0]}.
- Counter widths: `fcnt` is clog2(SETTLE_FRAMES+1) bits; `tcnt` is clog2(FVAL_TIMEOUT+1) bits. Both saturate and never wrap.

## Timing
- Reset (cycle where `iRst_n`=0): all outputs 0, `active`=0, `cand`=0, `req`=0, `dGray`=0, `fval_d`=0, state STEADY, counters 0. The pixel path restarts at fallback.
- Pixel latency: 1 cycle from `iCh_*`/`iGray` to `oWr*`. `dGray` is aligned with the same pixel.
- Request latency: an `iSelect` change reaches `cand` after 2 cycles.
- Switch timing: `active` updates on the `SETTLE_FRAMES`-th `fs` cycle. Pixel data from the next cycle uses the new source.
- Simultaneous events:
  - `fs` in the same cycle as a `req` change: the restart wins and the `fs` is not counted.
  - `fs` in the same cycle as the timeout: a single switch occurs.
- Reset asserted mid-PENDING: the pending request is discarded and the block returns to fallback.

## Test plan
Configuration for all scenarios: NUM_CH=4, PIX_W=12, SETTLE_FRAMES=2, FVAL_TIMEOUT=1000.

- Select ch1: after reset, `iSelect`=4'b0010; ch1 valid, RGB={12'hABC,12'h123,12'h456}, `iGray`=0; 2 frame starts → `oActive`=4'b0010; next cycle `oWr1_data`=16'h0914, `oWr2_data`=16'h22AC, valid=1.
- Glitch rejection: with ch1 active, `iSelect`=4'b0100 for one frame, then back to 4'b0010 → `oActive` stays 4'b0010; `oSwitching` high only during the excursion.
- Illegal select: `iSelect`=4'b0110, `iGray`=8'hFF, `iCh_Valid[0]`=1; 2 frames → `oActive`=0, `oWr1_data`=16'hFC03, `oWr2_data`=16'hFFFF, valid=1.
- Mark and invalid: ch1 active, valid=1, mark=1, gray=0 → Wr1=16'h0000, Wr2=16'h03FC, valid=1. Then valid=0 → both words 0, valid=0.
- Timeout: `iFval` held 0, `iSelect`=4'b1000 → `oActive`=4'b1000 exactly 1000 cycles after PENDING is entered; `oSwitching` then falls.
- Reset mid-pending: `iRst_n`=0 for 1 cycle during PENDING → all outputs 0, `oActive`=0, `oSwitching`=0; the next switch needs 2 fresh frame starts.

Source files
------------

// File: rtl/display_source_mux.sv
`default_nettype none
// ============================================================================
// Module   : display_source_mux
// Brief    : Frame-debounced pixel-source arbiter packing RGB plus gray into
//            the two 16-bit TCON write words.
// Revision : 1.0 - initial release
// ============================================================================
module display_source_mux #(
   parameter int                 NUM_CH        = 8,
   parameter int                 PIX_W         = 12,
   parameter int                 SETTLE_FRAMES = 2,
   parameter int                 FVAL_TIMEOUT  = 2**20,
   parameter logic [3*PIX_W-1:0] FALLBACK_RGB  = {8'hFF, {(PIX_W-8){1'b0}},
                                                  8'hFF, {(PIX_W-8){1'b0}},
                                                  {PIX_W{1'b0}}}
) (
   input  logic                       iClk,
   input  logic                       iRst_n,
   input  logic                       iFval,
   input  logic [NUM_CH-1:0]          iSelect,
   input  logic [NUM_CH*3*PIX_W-1:0]  iCh_RGB,
   input  logic [NUM_CH-1:0]          iCh_Valid,
   input  logic [NUM_CH-1:0]          iCh_Mark,
   input  logic [7:0]                 iGray,
   output logic [15:0]                oWr1_data,
   output logic [15:0]                oWr2_data,
   output logic                       oWr_data_valid,
   output logic [NUM_CH-1:0]          oActive,
   output logic                       oSwitching
);

   localparam int                 c_FW       = $clog2(SETTLE_FRAMES + 1);
   localparam int                 c_TW       = $clog2(FVAL_TIMEOUT + 1);
   localparam logic [c_FW-1:0]    c_SETTLE   = c_FW'(SETTLE_FRAMES);
   localparam logic [c_TW-1:0]    c_TIMEOUT  = c_TW'(FVAL_TIMEOUT);
   localparam logic [c_FW-1:0]    c_FONE     = c_FW'(1);
   localparam logic [c_TW-1:0]    c_TONE     = c_TW'(1);
   localparam logic [3*PIX_W-1:0] c_MARK_RGB = {8'hFF, {(3*PIX_W-8){1'b0}}};

   typedef enum logic [0:0] {
      STEADY  = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t              r_state;
   logic [NUM_CH-1:0]   r_req;
   logic [NUM_CH-1:0]   r_cand;
   logic [NUM_CH-1:0]   r_active;
   logic                r_fvalD;
   logic [7:0]          r_dGray;
   logic [c_FW-1:0]     r_fcnt;
   logic [c_TW-1:0]     r_tcnt;
   logic [7:0]          r_R8;
   logic [7:0]          r_G8;
   logic [7:0]          r_B8;
   logic                r_valid;

   logic [NUM_CH-1:0]   w_reqNorm;
   logic                w_fs;
   logic [c_FW-1:0]     w_fcntNext;
   logic [c_TW-1:0]     w_tcntNext;
   logic [3*PIX_W-1:0]  w_pixRGB;
   logic                w_pixValid;

   assign w_reqNorm  = $onehot(iSelect) ? iSelect : '0;
   assign w_fs       = iFval & ~r_fvalD;
   assign w_fcntNext = (r_fcnt == c_SETTLE)  ? r_fcnt : r_fcnt + c_FONE;
   assign w_tcntNext = (r_tcnt == c_TIMEOUT) ? r_tcnt : r_tcnt + c_TONE;

   // Pixel selection follows the applied source, never the raw request.
   always_comb begin
      w_pixRGB   = FALLBACK_RGB;
      w_pixValid = iCh_Valid[0];
      for (int k = 0; k < NUM_CH; k++) begin
         if (r_active[k]) begin
            w_pixValid = iCh_Valid[k];
            if (!iCh_Valid[k])
               w_pixRGB = '0;
            else if (iCh_Mark[k])
               w_pixRGB = c_MARK_RGB;
            else
               w_pixRGB = iCh_RGB[k*3*PIX_W +: 3*PIX_W];
         end
      end
   end

   generate
      if (PIX_W > 8) begin : g_lowBits
         logic w_unusedLow;
         assign w_unusedLow = ^{w_pixRGB[2*PIX_W +: PIX_W-8],
                                w_pixRGB[PIX_W   +: PIX_W-8],
                                w_pixRGB[0       +: PIX_W-8]};
      end
   endgenerate

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         r_state  <= STEADY;
         r_req    <= '0;
         r_cand   <= '0;
         r_active <= '0;
         r_fvalD  <= 1'b0;
         r_dGray  <= '0;
         r_fcnt   <= '0;
         r_tcnt   <= '0;
         r_R8     <= '0;
         r_G8     <= '0;
         r_B8     <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_req   <= w_reqNorm;
         r_fvalD <= iFval;
         r_dGray <= iGray;
         r_R8    <= w_pixRGB[3*PIX_W-1 -: 8];
         r_G8    <= w_pixRGB[2*PIX_W-1 -: 8];
         r_B8    <= w_pixRGB[PIX_W-1   -: 8];
         r_valid <= w_pixValid;

         // A request change restarts debouncing and swallows a coincident fs.
         if (r_req != r_cand) begin
            r_cand <= r_req;
            r_fcnt <= '0;
            r_tcnt <= '0;
            if (r_state == PENDING && r_req == r_active)
               r_state <= STEADY;
         end else if (r_cand == r_active) begin
            r_state <= STEADY;
         end else if (r_state == STEADY) begin
            r_state <= PENDING;
         end else if (w_fs) begin
            r_fcnt <= w_fcntNext;
            if (w_fcntNext >= c_SETTLE || r_tcnt >= c_TIMEOUT) begin
               r_active <= r_cand;
               r_state  <= STEADY;
            end
         end else begin
            r_tcnt <= w_tcntNext;
            if (w_tcntNext >= c_TIMEOUT) begin
               r_active <= r_cand;
               r_state  <= STEADY;
            end
         end
      end
   end

   assign oWr1_data      = {r_dGray[7], r_G8[7:3], r_B8, r_dGray[6:5]};
   assign oWr2_data      = {r_dGray[4], r_G8[2:0], r_dGray[3:2], r_R8, r_dGray[1:0]};
   assign oWr_data_valid = r_valid;
   assign oActive        = r_active;
   assign oSwitching     = (r_state == PENDING);

endmodule
`default_nettype wire

// File: tb/tb_display_source_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_source_mux
// Brief    : Scoreboard bench for display_source_mux (4 channels, 12-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_source_mux;

   localparam int c_WR1 = 0;
   localparam int c_WR2 = 1;
   localparam int c_VAL = 2;
   localparam int c_ACT = 3;
   localparam int c_SW  = 4;

   logic          iClk;
   logic          iRst_n;
   logic          iFval;
   logic [3:0]    iSelect;
   logic [143:0]  iCh_RGB;
   logic [3:0]    iCh_Valid;
   logic [3:0]    iCh_Mark;
   logic [7:0]    iGray;
   logic [15:0]   oWr1_data;
   logic [15:0]   oWr2_data;
   logic          oWr_data_valid;
   logic [3:0]    oActive;
   logic          oSwitching;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] exp;
      string       nm;
   } exp_t;

   exp_t sbq[$];
   int   cyc     = 0;
   int   nChecks = 0;
   int   nFails  = 0;

   display_source_mux #(
      .NUM_CH        (4),
      .PIX_W         (12),
      .SETTLE_FRAMES (2),
      .FVAL_TIMEOUT  (1000)
   ) dut (
      .iClk           (iClk),
      .iRst_n         (iRst_n),
      .iFval          (iFval),
      .iSelect        (iSelect),
      .iCh_RGB        (iCh_RGB),
      .iCh_Valid      (iCh_Valid),
      .iCh_Mark       (iCh_Mark),
      .iGray          (iGray),
      .oWr1_data      (oWr1_data),
      .oWr2_data      (oWr2_data),
      .oWr_data_valid (oWr_data_valid),
      .oActive        (oActive),
      .oSwitching     (oSwitching)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;
   always @(posedge iClk) cyc <= cyc + 1;

   function automatic void expectAt(input int c, input int sel, input logic [31:0] v, input string nm);
      exp_t e;
      e.cyc = c;
      e.sel = sel;
      e.exp = v;
      e.nm  = nm;
      sbq.push_back(e);
   endfunction

   function automatic void expectPix(input int c, input logic [15:0] w1, input logic [15:0] w2,
                                     input logic v, input string nm);
      expectAt(c, c_WR1, {16'h0, w1}, {nm, "_wr1"});
      expectAt(c, c_WR2, {16'h0, w2}, {nm, "_wr2"});
      expectAt(c, c_VAL, {31'h0, v},  {nm, "_valid"});
   endfunction

   // Monitor: pops every expectation due this cycle and compares it.
   always @(negedge iClk) begin
      logic [31:0] act;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         exp_t e;
         e = sbq.pop_front();
         nChecks++;
         if (e.cyc < cyc) begin
            nFails++;
            $display("FAIL %s: check for cycle %0d missed at cycle %0d, required %h", e.nm, e.cyc, cyc, e.exp);
         end else begin
            case (e.sel)
               c_WR1:   act = {16'h0, oWr1_data};
               c_WR2:   act = {16'h0, oWr2_data};
               c_VAL:   act = {31'h0, oWr_data_valid};
               c_ACT:   act = {28'h0, oActive};
               default: act = {31'h0, oSwitching};
            endcase
            if (act !== e.exp) begin
               nFails++;
               $display("FAIL %s @cycle %0d: actual %h, required %h", e.nm, cyc, act, e.exp);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge iClk);
         #1;
      end
   endtask

   task automatic pulse();
      iFval = 1'b1;
      tick(3);
      iFval = 1'b0;
      tick(3);
   endtask

   // Request a source and deliver two frame starts; checks the switch edge.
   task automatic doSwitch(input logic [3:0] sel, input logic [3:0] prevAct, input logic [3:0] newAct,
                           input logic [15:0] oldWr1, input logic [15:0] newWr1, input string nm);
      int f;
      iSelect = sel;
      tick(3);
      expectAt(cyc, c_SW, 32'd1, {nm, "_pending"});
      pulse();
      f = cyc;
      iFval = 1'b1;
      expectAt(f,     c_ACT, {28'h0, prevAct}, {nm, "_hold_before_2nd_fs"});
      expectAt(f + 1, c_ACT, {28'h0, newAct},  {nm, "_applied"});
      expectAt(f + 1, c_SW,  32'd0,            {nm, "_switch_done"});
      expectAt(f + 1, c_WR1, {16'h0, oldWr1},  {nm, "_old_src_pixel"});
      expectAt(f + 2, c_WR1, {16'h0, newWr1},  {nm, "_new_src_pixel"});
      tick(3);
      iFval = 1'b0;
      tick(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      iRst_n    = 1'b0;
      iFval     = 1'b0;
      iSelect   = 4'b0010;
      iCh_RGB   = {36'hDEF_CBA_987, 36'h777_888_999, 36'hABC_123_456, 36'h111_222_333};
      iCh_Valid = 4'b1111;
      iCh_Mark  = 4'b0000;
      iGray     = 8'hFF;
      tick(3);
      expectPix(cyc, 16'h0000, 16'h0000, 1'b0, "reset");
      expectAt(cyc, c_ACT, 32'd0, "reset_active");
      expectAt(cyc, c_SW,  32'd0, "reset_switching");

      // Release: fallback yellow with ch0 invalid.
      iRst_n    = 1'b1;
      iGray     = 8'h00;
      iCh_Valid = 4'b0010;
      expectPix(cyc + 1, 16'h7C00, 16'h73FC, 1'b0, "fallback_after_reset");

      doSwitch(4'b0010, 4'b0000, 4'b0010, 16'h7C00, 16'h0914, "sel_ch1");
      expectPix(cyc + 1, 16'h0914, 16'h22AC, 1'b1, "ch1_pixel");
      tick(2);

      // Glitch: one-frame excursion to ch2 and back.
      t = cyc;
      iSelect = 4'b0100;
      expectAt(t + 2, c_SW, 32'd0, "glitch_not_yet_pending");
      expectAt(t + 3, c_SW, 32'd1, "glitch_pending");
      tick(3);
      pulse();
      t = cyc;
      iSelect = 4'b0010;
      expectAt(t + 1, c_SW,  32'd1,       "glitch_still_pending");
      expectAt(t + 2, c_SW,  32'd0,       "glitch_cancelled");
      expectAt(t + 2, c_ACT, 32'h2,       "glitch_active_kept");
      tick(3);
      pulse();
      pulse();
      expectAt(cyc, c_ACT, 32'h2, "glitch_active_after_frames");
      tick(1);

      // Illegal multi-hot request falls back.
      iGray     = 8'hFF;
      iCh_Valid = 4'b0011;
      doSwitch(4'b0110, 4'b0010, 4'b0000, 16'h8917, 16'hFC03, "illegal");
      expectPix(cyc + 1, 16'hFC03, 16'hFFFF, 1'b1, "illegal_fallback_pixel");
      tick(2);

      // Back to ch1, then overlay mark and invalid pixel.
      iGray = 8'h00;
      doSwitch(4'b0010, 4'b0000, 4'b0010, 16'h7C00, 16'h0914, "reselect_ch1");
      iCh_Mark = 4'b0110;
      expectPix(cyc + 1, 16'h0000, 16'h03FC, 1'b1, "mark_red");
      tick(1);
      iCh_Valid = 4'b0001;
      expectPix(cyc + 1, 16'h0000, 16'h0000, 1'b0, "invalid_pixel");
      tick(2);

      // Timeout with no frame starts.
      iCh_Valid = 4'b1111;
      iCh_Mark  = 4'b0000;
      t = cyc;
      iSelect = 4'b1000;
      expectAt(t + 3,    c_SW,  32'd1, "timeout_pending");
      expectAt(t + 1002, c_ACT, 32'h2, "timeout_not_early");
      expectAt(t + 1002, c_SW,  32'd1, "timeout_pending_late");
      expectAt(t + 1003, c_ACT, 32'h8, "timeout_switch");
      expectAt(t + 1003, c_SW,  32'd0, "timeout_switch_done");
      expectAt(t + 1003, c_WR1, 32'h0914, "timeout_old_pixel");
      expectPix(t + 1004, 16'h6660, 16'h3378, 1'b1, "ch3_pixel");
      tick(1006);

      // Reset in the middle of a pending change.
      iGray   = 8'h5A;
      iSelect = 4'b0100;
      tick(3);
      expectAt(cyc, c_SW, 32'd1, "prereset_pending");
      pulse();
      iRst_n = 1'b0;
      expectPix(cyc + 1, 16'h0000, 16'h0000, 1'b0, "midreset");
      expectAt(cyc + 1, c_ACT, 32'd0, "midreset_active");
      expectAt(cyc + 1, c_SW,  32'd0, "midreset_switching");
      tick(1);
      iRst_n = 1'b1;
      doSwitch(4'b0100, 4'b0000, 4'b0100, 16'h7C02, 16'h4666, "post_reset_ch2");
      tick(3);

      while (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         nChecks++;
         nFails++;
         $display("FAIL %s: never evaluated, required %h", e.nm, e.exp);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
`default_nettype wire
